// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: pops words and presents them on a
// valid/ready stream through a 2-entry skid buffer. Optional feature macro: RD_XFER_CNT_EN.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush
`ifdef RD_XFER_CNT_EN
    ,
    output logic [CNTW-1:0]  xfer_cnt
`endif
);

    logic [1:0]       cnt_r;
    logic [1:0]       cnt_nxt_s;
    logic [DSIZE-1:0] head_r;
    logic [DSIZE-1:0] head_nxt_s;
    logic [DSIZE-1:0] skid_r;
    logic [DSIZE-1:0] skid_nxt_s;
    logic             valid_r;
    logic             run_r;
    logic             push_s;
    logic             pop_s;

    // run_r keeps rinc low in reset and for the first cycle after release
    assign push_s  = run_r & ~rempty & (cnt_r != 2'd2) & ~flush;
    assign pop_s   = valid_r & m_ready;
    assign rinc    = push_s;
    assign m_valid = valid_r;
    assign m_data  = head_r;

    // Skid-buffer next state; flush discards contents and ignores any pop
    always_comb begin
        cnt_nxt_s  = cnt_r;
        head_nxt_s = head_r;
        skid_nxt_s = skid_r;
        if (flush) begin
            cnt_nxt_s = 2'd0;
        end else begin
            case (cnt_r)
                2'd0: begin
                    if (push_s) begin
                        head_nxt_s = rdata;
                        cnt_nxt_s  = 2'd1;
                    end else begin
                        cnt_nxt_s  = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_nxt_s = rdata;
                        cnt_nxt_s  = 2'd1;
                    end else if (push_s) begin
                        skid_nxt_s = rdata;
                        cnt_nxt_s  = 2'd2;
                    end else if (pop_s) begin
                        cnt_nxt_s  = 2'd0;
                    end else begin
                        cnt_nxt_s  = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_nxt_s = skid_r;
                        cnt_nxt_s  = 2'd1;
                    end else begin
                        cnt_nxt_s  = 2'd2;
                    end
                end
                default: begin
                    cnt_nxt_s = 2'd0;
                end
            endcase
        end
    end

    // Buffer registers; m_valid is registered alongside the occupancy
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_r   <= 2'd0;
            head_r  <= {DSIZE{1'b0}};
            skid_r  <= {DSIZE{1'b0}};
            valid_r <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            head_r  <= head_nxt_s;
            skid_r  <= skid_nxt_s;
            valid_r <= (cnt_nxt_s != 2'd0);
            run_r   <= 1'b1;
        end
    end

`ifdef RD_XFER_CNT_EN
    logic [CNTW-1:0] xfer_r;

    assign xfer_cnt = xfer_r;

    // Completed-handshake counter; wraps, and a pop during flush is not counted
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            xfer_r <= {CNTW{1'b0}};
        end else if (pop_s && !flush) begin
            xfer_r <= xfer_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            xfer_r <= xfer_r;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO model plus expected-word scoreboard.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rrst_n;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       flush;
`ifdef RD_XFER_CNT_EN
    logic [3:0] xfer_cnt;
`endif

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
    int         n_vec = 0;
    int         n_err = 0;

    fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut (
        .rclk    (clk),
        .rrst_n  (rrst_n),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .flush   (flush)
`ifdef RD_XFER_CNT_EN
        ,
        .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Mid-cycle monitor: FIFO pops, empty-pop checks and the output scoreboard
    always @(negedge clk) begin
        if (rrst_n === 1'b1) begin
            n_vec++;
            if (rinc === 1'b1 && rempty === 1'b1) begin
                n_err++;
                $display("FAIL rinc_while_empty: rinc=%0b required 0", rinc);
            end
            if (rinc === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (m_valid === 1'b1 && m_ready === 1'b1 && flush === 1'b0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: got word %h, required no output", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (m_data !== exp_w) begin
                        n_err++;
                        $display("FAIL sb_data: got %h required %h", m_data, exp_w);
                    end
                end
            end
        end
    end

    task automatic tick(input logic rdy, input logic fl, input logic gap);
        @(posedge clk);
        #1;
        m_ready = rdy;
        flush   = fl;
        rempty  = gap || (fifo_q.size() == 0);
        rdata   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        fifo_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            n_vec++;
            if (rinc !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
                n_err++;
                $display("FAIL reset_state: rinc=%0b m_valid=%0b m_data=%h required 0 0 00",
                         rinc, m_valid, m_data);
            end
`ifdef RD_XFER_CNT_EN
            n_vec++;
            if (xfer_cnt !== 4'd0) begin
                n_err++;
                $display("FAIL reset_xfer: xfer_cnt=%0d required 0", xfer_cnt);
            end
`endif
        end
        @(posedge clk);
        #1;
        rrst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rinc !== 1'b0) begin
            n_err++;
            $display("FAIL release_cycle_rinc: rinc=%0b required 0", rinc);
        end
        tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (rinc !== 1'b1) begin
            n_err++;
            $display("FAIL first_rinc: rinc=%0b required 1", rinc);
        end
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 16; k++) begin
            fifo_q.push_back(8'(k));
            exp_q.push_back(8'(k));
        end
        for (int k = 0; k <= 16; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            n_vec++;
            if (rinc !== (k < 16)) begin
                n_err++;
                $display("FAIL b2b_rinc cycle %0d: rinc=%0b required %0b", k, rinc, (k < 16));
            end
            if (k >= 1) begin
                n_vec++;
                if (m_valid !== 1'b1 || m_data !== 8'(k)) begin
                    n_err++;
                    $display("FAIL b2b_data cycle %0d: valid=%0b data=%h required 1 %h",
                             k, m_valid, m_data, 8'(k));
                end
            end
        end
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        int pops;
        pops = 0;
        fifo_q.push_back(8'hA0); fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2);
        exp_q.push_back(8'hA0);  exp_q.push_back(8'hA1);  exp_q.push_back(8'hA2);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (rinc === 1'b1) pops++;
            if (k >= 1) begin
                n_vec++;
                if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
                    n_err++;
                    $display("FAIL stall_hold cycle %0d: valid=%0b data=%h required 1 a0",
                             k, m_valid, m_data);
                end
            end
        end
        n_vec++;
        if (pops != 2 || rinc !== 1'b0) begin
            n_err++;
            $display("FAIL stall_pops: pops=%0d rinc=%0b required 2 0", pops, rinc);
        end
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_drain: %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        exp_q.push_back(8'h33);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (m_data !== 8'h11 || rinc !== 1'b0) begin
            n_err++;
            $display("FAIL flush_pre: data=%h rinc=%0b required 11 0", m_data, rinc);
        end
        tick(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (rinc !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rinc: rinc=%0b required 0", rinc);
        end
        tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b0 || rinc !== 1'b1) begin
            n_err++;
            $display("FAIL flush_after: valid=%0b rinc=%0b required 0 1", m_valid, rinc);
        end
        tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 8'h33) begin
            n_err++;
            $display("FAIL flush_next: valid=%0b data=%h required 1 33", m_valid, m_data);
        end
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int i = 0; i < 1000; i++) begin
            w = 8'($urandom_range(0, 255));
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        for (int c = 0; c < 20000 && exp_q.size() > 0; c++)
            tick($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 3) == 0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_timeout: %0d words left, required 0", exp_q.size());
        end
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, 1'b0);
    endtask

`ifdef RD_XFER_CNT_EN
    task automatic test_xfer_cnt();
        @(posedge clk);
        #1;
        rrst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (xfer_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL xfer_reset: xfer_cnt=%0d required 0", xfer_cnt);
        end
        @(posedge clk);
        #1;
        rrst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            fifo_q.push_back(8'(8'hC0 + k));
            exp_q.push_back(8'(8'hC0 + k));
        end
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (xfer_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL xfer_wrap: xfer_cnt=%0d required 1", xfer_cnt);
        end
        fifo_q.push_back(8'h44); fifo_q.push_back(8'h55);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (xfer_cnt !== 4'd1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL xfer_flush: xfer_cnt=%0d valid=%0b required 1 0", xfer_cnt, m_valid);
        end
    endtask
`endif

    initial begin
        rrst_n  = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        rempty  = 1'b1;
        rdata   = 8'h00;
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_random();
`ifdef RD_XFER_CNT_EN
        test_xfer_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
